// File: rtl/operand_fetch_stage.sv
// Operand fetch stage: reads three sources from the register file with writeback
// bypass, tracks in-flight destinations in a scoreboard and stalls on RAW/WAW hazards.
module operand_fetch_stage #(
  parameter int WORD_W      = 32,
  parameter int NREGS       = 16,
  parameter int INSTR_W     = 32,
  parameter int STALL_CNT_W = 16,
  localparam int AW         = $clog2(NREGS)
) (
  input  logic                   clk,
  input  logic                   rst,
  // Upstream and downstream follow valid/ready: a transfer happens on a rising
  // edge where valid and ready are both 1; valid may not depend on ready.
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [INSTR_W-1:0]     in_instr,
  input  logic [AW-1:0]          in_rs_a,
  input  logic [AW-1:0]          in_rs_b,
  input  logic [AW-1:0]          in_rs_c,
  input  logic [AW-1:0]          in_rd,
  input  logic                   in_rd_en,
  output logic [AW-1:0]          rf_rd_addr_0,
  output logic [AW-1:0]          rf_rd_addr_1,
  output logic [AW-1:0]          rf_rd_addr_2,
  input  logic [WORD_W-1:0]      rf_rd_data_0,
  input  logic [WORD_W-1:0]      rf_rd_data_1,
  input  logic [WORD_W-1:0]      rf_rd_data_2,
  input  logic                   wb_en_0,
  input  logic                   wb_en_1,
  input  logic [AW-1:0]          wb_addr_0,
  input  logic [AW-1:0]          wb_addr_1,
  input  logic [WORD_W-1:0]      wb_data_0,
  input  logic [WORD_W-1:0]      wb_data_1,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [INSTR_W-1:0]     out_instr,
  output logic [WORD_W-1:0]      out_a,
  output logic [WORD_W-1:0]      out_b,
  output logic [WORD_W-1:0]      out_c,
  output logic [AW-1:0]          out_rd,
  output logic                   out_rd_en,
  output logic [STALL_CNT_W-1:0] stall_cnt
);

  logic                   eff_0, eff_1;
  logic [NREGS-1:0]       wr_hit, busy, set_vec;
  logic [NREGS-1:0]       sb_q, sb_d;
  logic [STALL_CNT_W-1:0] stall_q, stall_d;
  logic                   out_valid_q, out_valid_d;
  logic [INSTR_W-1:0]     instr_q;
  logic [WORD_W-1:0]      a_q, b_q, c_q;
  logic [WORD_W-1:0]      op_a, op_b, op_c;
  logic [AW-1:0]          rd_q;
  logic                   rd_en_q;
  logic                   hazard, accept;

  // Port 1 is checked first so it wins when both ports write the same register.
  function automatic logic [WORD_W-1:0] pick_operand(
    input logic [AW-1:0]     r,
    input logic [WORD_W-1:0] rf,
    input logic              e0,
    input logic [AW-1:0]     a0,
    input logic [WORD_W-1:0] d0,
    input logic              e1,
    input logic [AW-1:0]     a1,
    input logic [WORD_W-1:0] d1
  );
    if (r == '0)              return '0;
    else if (e1 && (a1 == r)) return d1;
    else if (e0 && (a0 == r)) return d0;
    else                      return rf;
  endfunction

  assign rf_rd_addr_0 = in_rs_a;
  assign rf_rd_addr_1 = in_rs_b;
  assign rf_rd_addr_2 = in_rs_c;

  assign eff_0 = wb_en_0 && (wb_addr_0 != '0);
  assign eff_1 = wb_en_1 && (wb_addr_1 != '0);

  assign op_a = pick_operand(in_rs_a, rf_rd_data_0, eff_0, wb_addr_0, wb_data_0,
                             eff_1, wb_addr_1, wb_data_1);
  assign op_b = pick_operand(in_rs_b, rf_rd_data_1, eff_0, wb_addr_0, wb_data_0,
                             eff_1, wb_addr_1, wb_data_1);
  assign op_c = pick_operand(in_rs_c, rf_rd_data_2, eff_0, wb_addr_0, wb_data_0,
                             eff_1, wb_addr_1, wb_data_1);

  always_comb begin
    wr_hit = '0;
    if (eff_0) wr_hit[wb_addr_0] = 1'b1;
    if (eff_1) wr_hit[wb_addr_1] = 1'b1;
  end

  // A register being written this cycle is no longer a hazard.
  assign busy = sb_q & ~wr_hit;

  assign hazard = in_valid && (
                    ((in_rs_a != '0) && busy[in_rs_a]) ||
                    ((in_rs_b != '0) && busy[in_rs_b]) ||
                    ((in_rs_c != '0) && busy[in_rs_c]) ||
                    (in_rd_en && (in_rd != '0) && busy[in_rd]));

  assign in_ready = !rst && !hazard && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;

  always_comb begin
    set_vec = '0;
    if (accept && in_rd_en && (in_rd != '0)) set_vec[in_rd] = 1'b1;
    sb_d = busy | set_vec;
  end

  always_comb begin
    out_valid_d = out_valid_q;
    if (accept)         out_valid_d = 1'b1;
    else if (out_ready) out_valid_d = 1'b0;
    stall_d = stall_q;
    if (hazard && (stall_q != '1)) stall_d = stall_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      instr_q     <= '0;
      a_q         <= '0;
      b_q         <= '0;
      c_q         <= '0;
      rd_q        <= '0;
      rd_en_q     <= 1'b0;
      sb_q        <= '0;
      stall_q     <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      sb_q        <= sb_d;
      stall_q     <= stall_d;
      if (accept) begin
        instr_q <= in_instr;
        a_q     <= op_a;
        b_q     <= op_b;
        c_q     <= op_c;
        rd_q    <= in_rd;
        rd_en_q <= in_rd_en;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_instr = instr_q;
  assign out_a     = a_q;
  assign out_b     = b_q;
  assign out_c     = c_q;
  assign out_rd    = rd_q;
  assign out_rd_en = rd_en_q;
  assign stall_cnt = stall_q;

endmodule

// File: tb/tb_operand_fetch_stage.sv
// Bench for operand_fetch_stage: directed scenarios then random traffic, each
// cycle compared against a register-level model of pending writes and outputs.
module tb_operand_fetch_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, in_rd_en;
  logic [31:0] in_instr;
  logic [3:0]  in_rs_a, in_rs_b, in_rs_c, in_rd;
  logic [3:0]  rf_rd_addr_0, rf_rd_addr_1, rf_rd_addr_2;
  logic [31:0] rf_rd_data_0, rf_rd_data_1, rf_rd_data_2;
  logic        wb_en_0, wb_en_1;
  logic [3:0]  wb_addr_0, wb_addr_1;
  logic [31:0] wb_data_0, wb_data_1;
  logic        out_valid, out_ready, out_rd_en;
  logic [31:0] out_instr, out_a, out_b, out_c;
  logic [3:0]  out_rd;
  logic [15:0] stall_cnt;

  logic [31:0] rf_mem [16];

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  bit          m_pend [16];
  bit          m_valid;
  logic [31:0] m_instr, m_a, m_b, m_c;
  logic [3:0]  m_rd;
  bit          m_rd_en;
  int          m_stall;

  always #5 clk = ~clk;

  // The register file itself lives in the bench
  assign rf_rd_data_0 = rf_mem[in_rs_a];
  assign rf_rd_data_1 = rf_mem[in_rs_b];
  assign rf_rd_data_2 = rf_mem[in_rs_c];

  operand_fetch_stage dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .in_rs_a(in_rs_a), .in_rs_b(in_rs_b), .in_rs_c(in_rs_c),
    .in_rd(in_rd), .in_rd_en(in_rd_en),
    .rf_rd_addr_0(rf_rd_addr_0), .rf_rd_addr_1(rf_rd_addr_1), .rf_rd_addr_2(rf_rd_addr_2),
    .rf_rd_data_0(rf_rd_data_0), .rf_rd_data_1(rf_rd_data_1), .rf_rd_data_2(rf_rd_data_2),
    .wb_en_0(wb_en_0), .wb_en_1(wb_en_1),
    .wb_addr_0(wb_addr_0), .wb_addr_1(wb_addr_1),
    .wb_data_0(wb_data_0), .wb_data_1(wb_data_1),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_a(out_a), .out_b(out_b), .out_c(out_c),
    .out_rd(out_rd), .out_rd_en(out_rd_en), .stall_cnt(stall_cnt)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit written(int r);
    return (r != 0) && ((wb_en_0 && int'(wb_addr_0) == r) || (wb_en_1 && int'(wb_addr_1) == r));
  endfunction

  function automatic bit blocked(int r);
    return (r != 0) && m_pend[r] && !written(r);
  endfunction

  function automatic logic [31:0] operand(int r);
    if (r == 0) return 32'h0;
    if (wb_en_1 && int'(wb_addr_1) == r) return wb_data_1;
    if (wb_en_0 && int'(wb_addr_0) == r) return wb_data_0;
    return rf_mem[r];
  endfunction

  task automatic set_in(input bit v, input int a, input int b, input int c,
                        input int rd, input bit rd_en, input logic [31:0] instr);
    in_valid = v;
    in_rs_a  = 4'(a);
    in_rs_b  = 4'(b);
    in_rs_c  = 4'(c);
    in_rd    = 4'(rd);
    in_rd_en = rd_en;
    in_instr = instr;
  endtask

  task automatic set_wb(input bit e0, input int a0, input logic [31:0] d0,
                        input bit e1, input int a1, input logic [31:0] d1);
    wb_en_0 = e0; wb_addr_0 = 4'(a0); wb_data_0 = d0;
    wb_en_1 = e1; wb_addr_1 = 4'(a1); wb_data_1 = d1;
  endtask

  // One clock: check combinational outputs, advance the model, check registers.
  task automatic cycle();
    bit haz, exp_ready, acc;
    #2;
    haz = in_valid && (blocked(int'(in_rs_a)) || blocked(int'(in_rs_b)) ||
                       blocked(int'(in_rs_c)) || (in_rd_en && blocked(int'(in_rd))));
    exp_ready = !rst && !haz && (!m_valid || out_ready);
    acc = in_valid && exp_ready;
    check("in_ready", in_ready, exp_ready);
    check("rf_rd_addr_0", rf_rd_addr_0, in_rs_a);
    check("rf_rd_addr_1", rf_rd_addr_1, in_rs_b);
    check("rf_rd_addr_2", rf_rd_addr_2, in_rs_c);
    if (rst) begin
      m_valid = 0; m_instr = 0; m_a = 0; m_b = 0; m_c = 0; m_rd = 0; m_rd_en = 0;
      m_stall = 0;
      foreach (m_pend[r]) m_pend[r] = 0;
    end else begin
      if (acc) begin
        m_valid = 1;
        m_instr = in_instr;
        m_a = operand(int'(in_rs_a));
        m_b = operand(int'(in_rs_b));
        m_c = operand(int'(in_rs_c));
        m_rd = in_rd;
        m_rd_en = in_rd_en;
      end else if (out_ready) begin
        m_valid = 0;
      end
      for (int r = 1; r < 16; r++) if (written(r)) m_pend[r] = 0;
      if (acc && in_rd_en && in_rd != 0) m_pend[in_rd] = 1;
      if (haz && m_stall < 65535) m_stall++;
    end
    @(posedge clk);
    if (wb_en_0 && wb_addr_0 != 0) rf_mem[wb_addr_0] = wb_data_0;
    if (wb_en_1 && wb_addr_1 != 0) rf_mem[wb_addr_1] = wb_data_1;
    #1;
    check("out_valid", out_valid, m_valid);
    check("out_instr", out_instr, m_instr);
    check("out_a", out_a, m_a);
    check("out_b", out_b, m_b);
    check("out_c", out_c, m_c);
    check("out_rd", out_rd, m_rd);
    check("out_rd_en", out_rd_en, m_rd_en);
    check("stall_cnt", stall_cnt, 64'(m_stall));
  endtask

  initial begin
    for (int i = 0; i < 16; i++) rf_mem[i] = 32'h11 * i;
    foreach (m_pend[r]) m_pend[r] = 0;
    m_valid = 0; m_instr = 0; m_a = 0; m_b = 0; m_c = 0; m_rd = 0; m_rd_en = 0;
    m_stall = 0;
    rst = 1'b1;
    out_ready = 1'b1;
    set_in(0, 0, 0, 0, 0, 0, 0);
    set_wb(0, 0, 0, 0, 0, 0);
    cycle();
    cycle();
    rst = 1'b0;

    // Basic read with rs_c = r0
    set_in(1, 1, 2, 0, 0, 0, 32'h1000);
    cycle();
    check("tp1_out_a", out_a, 32'h11);
    check("tp1_out_b", out_b, 32'h22);
    check("tp1_out_c", out_c, 32'h0);

    // RAW stall on r5, released by a same-cycle writeback bypass
    set_in(1, 0, 0, 0, 5, 1, 32'h2000);
    cycle();
    set_in(1, 5, 0, 0, 0, 0, 32'h3000);
    #2 check("tp2_raw_stall", in_ready, 1'b0);
    cycle(); cycle(); cycle();
    check("tp2_stall_count", stall_cnt, 16'd3);
    set_wb(1, 5, 32'hDEADBEEF, 0, 0, 0);
    #2 check("tp2_bypass_ready", in_ready, 1'b1);
    cycle();
    check("tp2_bypass_a", out_a, 32'hDEADBEEF);
    set_wb(0, 0, 0, 0, 0, 0);
    set_in(1, 5, 5, 5, 0, 0, 32'h3001);
    #2 check("tp2_sb5_clear", in_ready, 1'b1);
    cycle();

    // Both ports write r3: port 1 wins
    set_in(1, 0, 3, 0, 0, 0, 32'h4000);
    set_wb(1, 3, 32'hAAAA0000, 1, 3, 32'h5555FFFF);
    cycle();
    check("tp3_port1_wins", out_b, 32'h5555FFFF);
    set_wb(0, 0, 0, 0, 0, 0);

    // WAW on r7 cleared in the same cycle: set wins
    set_in(1, 0, 0, 0, 7, 1, 32'h5000);
    cycle();
    set_in(1, 0, 0, 0, 7, 1, 32'h5001);
    set_wb(1, 7, 32'h77, 0, 0, 0);
    #2 check("tp4_waw_clear_ready", in_ready, 1'b1);
    cycle();
    set_wb(0, 0, 0, 0, 0, 0);
    set_in(1, 7, 0, 0, 0, 0, 32'h5002);
    #2 check("tp4_set_wins", in_ready, 1'b0);
    cycle();
    set_wb(0, 0, 0, 1, 7, 32'h7777);
    cycle();
    set_wb(0, 0, 0, 0, 0, 0);

    // Back-pressure: bundle held, no stall counting
    out_ready = 1'b0;
    set_in(1, 1, 2, 3, 0, 0, 32'h6000);
    for (int i = 0; i < 4; i++) begin
      #2 check("tp5_backpressure", in_ready, 1'b0);
      cycle();
    end
    out_ready = 1'b1;
    cycle();
    check("tp5_released_instr", out_instr, 32'h6000);

    // Reset mid-transfer with r4 pending
    set_in(1, 0, 0, 0, 4, 1, 32'h7000);
    cycle();
    out_ready = 1'b0;
    set_in(0, 0, 0, 0, 0, 0, 0);
    cycle();
    rst = 1'b1;
    cycle();
    check("tp6_rst_valid", out_valid, 1'b0);
    check("tp6_rst_stall", stall_cnt, 16'd0);
    rst = 1'b0;
    out_ready = 1'b1;
    set_in(1, 4, 0, 0, 0, 0, 32'h7001);
    #2 check("tp6_sb_cleared", in_ready, 1'b1);
    cycle();

    // Random traffic
    for (int i = 0; i < 16; i++) rf_mem[i] = (i == 0) ? 32'h0 : $urandom;
    for (int n = 0; n < 600; n++) begin
      rst = ($urandom_range(0, 99) == 0);
      out_ready = ($urandom_range(0, 3) != 0);
      set_in($urandom_range(0, 3) != 0, $urandom_range(0, 7), $urandom_range(0, 7),
             $urandom_range(0, 7), $urandom_range(0, 7), 1'($urandom_range(0, 1)), $urandom);
      set_wb(1'($urandom_range(0, 1)), $urandom_range(0, 7), $urandom,
             1'($urandom_range(0, 1)), $urandom_range(0, 7), $urandom);
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
